// File: rtl/cmp_pkg.sv
// Shared result encodings and FSM state type for the sequential magnitude comparator.
package cmp_pkg;

  localparam int unsigned R_W = 3;

  localparam logic [R_W-1:0] R_GT   = 3'b100;
  localparam logic [R_W-1:0] R_EQ   = 3'b010;
  localparam logic [R_W-1:0] R_LT   = 3'b001;
  localparam logic [R_W-1:0] R_NONE = 3'b000;

  typedef enum logic {
    IDLE = 1'b0,
    CMP  = 1'b1
  } state_e;

endpackage

// File: rtl/slice_comparator.sv
// Combinational unsigned compare of one SLICE-bit operand pair.
module slice_comparator #(
  parameter int unsigned SLICE = 4
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  output logic             gt_c_o,
  output logic             eq_c_o,
  output logic             lt_c_o
);

  assign gt_c_o = (a_i > b_i);
  assign eq_c_o = (a_i == b_i);
  assign lt_c_o = (a_i < b_i);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator: walks SLICE-bit slices MSB-first and
// stops at the first differing slice; start/busy/done handshake, registered one-hot result.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [R_W-1:0]   r
);

  localparam int unsigned NUM_SLICES = WIDTH / SLICE;
  localparam int unsigned IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NUM_SLICES - 1);
  localparam logic [SLICE-1:0] MSB_MASK = SLICE'(1) << (SLICE - 1);

  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $fatal(1, "seq_magnitude_comparator: WIDTH (%0d) must be a multiple of SLICE (%0d)",
           WIDTH, SLICE);
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             signed_q, signed_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [R_W-1:0]   r_q, r_d;
  logic             done_q, done_d;

  logic             flip_c;
  logic [SLICE-1:0] a_top_c, b_top_c;
  logic             gt_c, eq_c, lt_c;

  // Signed compare: flipping the sign bit of the top slice maps two's complement to offset binary.
  assign flip_c  = signed_q && (idx_q == IDX_TOP);
  assign a_top_c = a_q[WIDTH-1 -: SLICE] ^ (flip_c ? MSB_MASK : '0);
  assign b_top_c = b_q[WIDTH-1 -: SLICE] ^ (flip_c ? MSB_MASK : '0);

  slice_comparator #(
    .SLICE (SLICE)
  ) u_slice (
    .a_i    (a_top_c),
    .b_i    (b_top_c),
    .gt_c_o (gt_c),
    .eq_c_o (eq_c),
    .lt_c_o (lt_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      idx_q    <= '0;
      r_q      <= R_NONE;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      idx_q    <= idx_d;
      r_q      <= r_d;
      done_q   <= done_d;
    end
  end

  // Abort takes priority over completion so an aborted compare never reports.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    idx_d    = idx_q;
    r_d      = r_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CMP;
          a_d      = a;
          b_d      = b;
          signed_d = signed_mode;
          idx_d    = IDX_TOP;
        end
      end
      CMP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!eq_c) begin
          r_d     = {gt_c, 1'b0, lt_c};
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (idx_q == '0) begin
          r_d     = R_EQ;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          a_d   = a_q << SLICE;
          b_d   = b_q << SLICE;
          idx_d = idx_q - IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == CMP);
  assign done = done_q;
  assign r    = r_q;

endmodule
